// File: rtl/bus_trace_capture.sv
// rtl/bus_trace_capture.sv - bus snooping trace capture with address trigger; optional TRACE_TIMESTAMP_EN
module bus_trace_capture #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IRQ_W  = 2,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [ADDR_W-1:0]                    BUS_ADDR,
    input  logic [DATA_W-1:0]                    BUS_DATA,
    input  logic                                 BUS_WE,
    input  logic                                 BUS_RE,
    input  logic [IRQ_W-1:0]                     BUS_IRQ,
    input  logic                                 ARM,
    input  logic                                 STOP,
    input  logic [ADDR_W-1:0]                    TRIG_ADDR,
    input  logic [ADDR_W-1:0]                    TRIG_MASK,
    input  logic [$clog2(DEPTH)-1:0]             POST_COUNT,
    input  logic [$clog2(DEPTH)-1:0]             RD_IDX,
    output logic [IRQ_W+2+ADDR_W+DATA_W-1:0]     RD_ENTRY,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]                      RD_TS,
`endif
    output logic [1:0]                           STATE,
    output logic [$clog2(DEPTH):0]               COUNT,
    output logic [$clog2(DEPTH)-1:0]             TRIG_POS,
    output logic                                 TRIGGERED
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int E_W   = IRQ_W + 2 + ADDR_W + DATA_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int STORED_TS_W = TS_W;
`else
    localparam int STORED_TS_W = 0 * TS_W;
`endif
    localparam int MEM_W = E_W + STORED_TS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   wr_ptr;
    logic [IDX_W:0]     count;
    logic [IDX_W-1:0]   trig_ptr;
    logic               triggered;
    logic [IDX_W-1:0]   remaining;
    logic [MEM_W-1:0]   mem [DEPTH];
    logic [MEM_W-1:0]   rd_q;
    logic [MEM_W-1:0]   wr_data;
    logic [E_W-1:0]     entry;
    logic [IDX_W-1:0]   oldest;
    logic [IDX_W-1:0]   rd_addr;
    logic               txn;
    logic               capture;
    logic               hit;

    assign txn     = BUS_WE | BUS_RE;
    // ARM restarts the capture, so a transaction in the ARM cycle is dropped
    assign capture = txn && !ARM && (state == ARMED || state == POST);
    assign hit     = capture && (state == ARMED) && (((BUS_ADDR ^ TRIG_ADDR) & TRIG_MASK) == '0);
    assign entry   = {BUS_IRQ, BUS_WE, BUS_RE, BUS_ADDR, BUS_DATA};

    // once the ring has wrapped, the slot about to be written holds the oldest entry
    assign oldest   = count[IDX_W] ? wr_ptr : '0;
    assign rd_addr  = oldest + RD_IDX;
    assign TRIG_POS = trig_ptr - oldest;

    assign STATE     = state;
    assign COUNT     = count;
    assign TRIGGERED = triggered;
    assign RD_ENTRY  = rd_q[E_W-1:0];

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // free-running capture timestamp, restarted by ARM and held at all-ones
    always_ff @(posedge CLK) begin
        if (RESET || ARM) begin
            ts_cnt <= '0;
        end else if ((state == ARMED || state == POST) && ts_cnt != '1) begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign wr_data = {ts_cnt, entry};
    assign RD_TS   = rd_q[MEM_W-1:E_W];
`else
    assign wr_data = entry;
`endif

    // state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: ARM wins over everything, STOP ends an active capture
    always_comb begin
        state_next = state;
        if (ARM) begin
            state_next = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (STOP || (hit && POST_COUNT == '0)) begin
                        state_next = DONE;
                    end else if (hit) begin
                        state_next = POST;
                    end
                end
                POST: begin
                    if (STOP || (capture && remaining == IDX_W'(1))) begin
                        state_next = DONE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // write pointer, fill count, trigger bookkeeping and post-trigger countdown
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr    <= '0;
            count     <= '0;
            trig_ptr  <= '0;
            triggered <= 1'b0;
            remaining <= '0;
        end else if (ARM) begin
            wr_ptr    <= '0;
            count     <= '0;
            triggered <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
                if (!count[IDX_W]) begin
                    count <= count + (IDX_W + 1)'(1);
                end
            end
            if (hit) begin
                trig_ptr  <= wr_ptr;
                triggered <= 1'b1;
                remaining <= POST_COUNT;
            end else if (capture && state == POST) begin
                remaining <= remaining - IDX_W'(1);
            end
        end
    end

    // trace RAM write port; contents survive reset
    always_ff @(posedge CLK) begin
        if (capture) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // registered readout; a same-slot write this cycle is not yet visible
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_bus_trace_capture.sv
// tb/tb_bus_trace_capture.sv - self-checking bench for bus_trace_capture
module tb_bus_trace_capture;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int IRQ_W  = 2;
    localparam int DEPTH  = 64;
    localparam int TS_W   = 16;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int E_W    = IRQ_W + 2 + ADDR_W + DATA_W;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [ADDR_W-1:0] BUS_ADDR;
    logic [DATA_W-1:0] BUS_DATA;
    logic              BUS_WE;
    logic              BUS_RE;
    logic [IRQ_W-1:0]  BUS_IRQ;
    logic              ARM;
    logic              STOP;
    logic [ADDR_W-1:0] TRIG_ADDR;
    logic [ADDR_W-1:0] TRIG_MASK;
    logic [IDX_W-1:0]  POST_COUNT;
    logic [IDX_W-1:0]  RD_IDX;
    logic [E_W-1:0]    RD_ENTRY;
    logic [TS_W-1:0]   RD_TS;
    logic [1:0]        STATE;
    logic [IDX_W:0]    COUNT;
    logic [IDX_W-1:0]  TRIG_POS;
    logic              TRIGGERED;

    int n_tests = 0;
    int n_fail  = 0;

    bus_trace_capture #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IRQ_W(IRQ_W), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA),
        .BUS_WE(BUS_WE),
        .BUS_RE(BUS_RE),
        .BUS_IRQ(BUS_IRQ),
        .ARM(ARM),
        .STOP(STOP),
        .TRIG_ADDR(TRIG_ADDR),
        .TRIG_MASK(TRIG_MASK),
        .POST_COUNT(POST_COUNT),
        .RD_IDX(RD_IDX),
        .RD_ENTRY(RD_ENTRY),
`ifdef TRACE_TIMESTAMP_EN
        .RD_TS(RD_TS),
`endif
        .STATE(STATE),
        .COUNT(COUNT),
        .TRIG_POS(TRIG_POS),
        .TRIGGERED(TRIGGERED)
    );

`ifndef TRACE_TIMESTAMP_EN
    assign RD_TS = '0;
`endif

    always #5 CLK = ~CLK;

    typedef struct {
        int             scen;
        string          name;
        int             idx;
        logic [E_W-1:0] exp_e;
        logic [TS_W-1:0] exp_ts;
        logic           chk_ts;
    } rd_vec_t;

    rd_vec_t vecs[$];
    rd_vec_t sb[$];

    function automatic logic [E_W-1:0] ent(logic [IRQ_W-1:0] irq, logic we, logic re,
                                           logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        return {irq, we, re, a, d};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus(logic we, logic re, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                       logic [IRQ_W-1:0] irq);
        BUS_WE = we; BUS_RE = re; BUS_ADDR = a; BUS_DATA = d; BUS_IRQ = irq;
        step();
        BUS_WE = 1'b0; BUS_RE = 1'b0; BUS_ADDR = '0; BUS_DATA = '0; BUS_IRQ = '0;
    endtask

    task automatic pulse_arm(logic with_stop);
        ARM = 1'b1; STOP = with_stop;
        step();
        ARM = 1'b0; STOP = 1'b0;
    endtask

    task automatic run_reads(int scen);
        rd_vec_t e;
        foreach (vecs[i]) begin
            if (vecs[i].scen == scen) begin
                RD_IDX = IDX_W'(vecs[i].idx);
                sb.push_back(vecs[i]);
                step();
                e = sb.pop_front();
                check(e.name, 32'(RD_ENTRY), 32'(e.exp_e));
                if (e.chk_ts) check({e.name, "_ts"}, 32'(RD_TS), 32'(e.exp_ts));
            end
        end
    endtask

    initial begin
        vecs.push_back('{1, "s1_idx0", 0, ent(2'b00, 1'b1, 1'b0, 8'd10, 8'h8A), '0, 1'b0});
        vecs.push_back('{1, "s1_idx1", 1, ent(2'b00, 1'b1, 1'b0, 8'd11, 8'h8B), '0, 1'b0});
        vecs.push_back('{1, "s1_idx2", 2, ent(2'b00, 1'b1, 1'b0, 8'd12, 8'h8C), '0, 1'b0});
        vecs.push_back('{1, "s1_idx3", 3, ent(2'b00, 1'b1, 1'b0, 8'd13, 8'h8D), '0, 1'b0});
        vecs.push_back('{2, "s2_idx63", 63, ent(2'b00, 1'b1, 1'b0, 8'hC0, 8'h5A), '0, 1'b0});
        vecs.push_back('{2, "s2_idx0", 0, ent(2'b01, 1'b0, 1'b1, 8'd37, 8'd37 ^ 8'h33), '0, 1'b0});
        vecs.push_back('{2, "s2_idx1", 1, ent(2'b01, 1'b0, 1'b1, 8'd38, 8'd38 ^ 8'h33), '0, 1'b0});
        vecs.push_back('{2, "s2_idx62", 62, ent(2'b01, 1'b0, 1'b1, 8'd99, 8'd99 ^ 8'h33), '0, 1'b0});
        vecs.push_back('{3, "s3_idx0", 0, ent(2'b00, 1'b0, 1'b1, 8'd1, 8'h11), '0, 1'b0});
        vecs.push_back('{3, "s3_idx5", 5, ent(2'b00, 1'b1, 1'b0, 8'h20, 8'hE7), '0, 1'b0});
        vecs.push_back('{4, "s4_idx0", 0, ent(2'b00, 1'b0, 1'b1, 8'h50, 8'h05), '0, 1'b0});
        vecs.push_back('{4, "s4_idx1", 1, ent(2'b00, 1'b1, 1'b0, 8'h51, 8'h06), '0, 1'b0});
        vecs.push_back('{5, "s5_idx0", 0, ent(2'b10, 1'b1, 1'b1, 8'h03, 8'h77), '0, 1'b0});
`ifdef TRACE_TIMESTAMP_EN
        vecs.push_back('{6, "s6_idx0", 0, ent(2'b01, 1'b0, 1'b1, 8'h44, 8'h99), 16'd7, 1'b1});
`else
        vecs.push_back('{6, "s6_idx0", 0, ent(2'b01, 1'b0, 1'b1, 8'h44, 8'h99), 16'd0, 1'b0});
`endif

        RESET = 1'b1; BUS_ADDR = '0; BUS_DATA = '0; BUS_WE = 1'b0; BUS_RE = 1'b0; BUS_IRQ = '0;
        ARM = 1'b0; STOP = 1'b0; TRIG_ADDR = '0; TRIG_MASK = '0; POST_COUNT = '0; RD_IDX = '0;
        step(); step();
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_trig_pos", 32'(TRIG_POS), 32'd0);
        check("rst_triggered", 32'(TRIGGERED), 32'd0);
        check("rst_rd_entry", 32'(RD_ENTRY), 32'd0);
        RESET = 1'b0;

        // 1: mask 0 triggers on the first write, three more captured after it
        TRIG_MASK = 8'h00; POST_COUNT = 6'd3;
        pulse_arm(1'b0);
        check("s1_armed", 32'(STATE), 32'd1);
        for (int a = 10; a <= 13; a++) bus(1'b1, 1'b0, 8'(a), 8'(a) + 8'h80, 2'b00);
        check("s1_done", 32'(STATE), 32'd3);
        bus(1'b1, 1'b0, 8'd14, 8'h8E, 2'b00);
        check("s1_count", 32'(COUNT), 32'd4);
        check("s1_trig_pos", 32'(TRIG_POS), 32'd0);
        check("s1_triggered", 32'(TRIGGERED), 32'd1);
        run_reads(1);

        // 2: ring wraps, trigger lands on the newest entry
        TRIG_ADDR = 8'hC0; TRIG_MASK = 8'hFF; POST_COUNT = 6'd0;
        pulse_arm(1'b0);
        for (int a = 0; a < 100; a++) bus(1'b0, 1'b1, 8'(a), 8'(a) ^ 8'h33, 2'b01);
        check("s2_armed_before_trig", 32'(STATE), 32'd1);
        bus(1'b1, 1'b0, 8'hC0, 8'h5A, 2'b00);
        check("s2_done", 32'(STATE), 32'd3);
        check("s2_count", 32'(COUNT), 32'd64);
        check("s2_trig_pos", 32'(TRIG_POS), 32'd63);
        check("s2_triggered", 32'(TRIGGERED), 32'd1);
        run_reads(2);

        // 3: STOP with a simultaneous write, no trigger
        TRIG_ADDR = 8'hFF; TRIG_MASK = 8'hFF;
        pulse_arm(1'b0);
        for (int a = 1; a <= 5; a++) bus(1'b0, 1'b1, 8'(a), 8'(a) * 8'h11, 2'b00);
        STOP = 1'b1;
        bus(1'b1, 1'b0, 8'h20, 8'hE7, 2'b00);
        STOP = 1'b0;
        check("s3_done", 32'(STATE), 32'd3);
        check("s3_count", 32'(COUNT), 32'd6);
        check("s3_triggered", 32'(TRIGGERED), 32'd0);
        bus(1'b1, 1'b0, 8'h21, 8'h00, 2'b00);
        check("s3_no_capture_done", 32'(COUNT), 32'd6);
        run_reads(3);

        // 4: reset aborts POST, re-arm and capture two fresh entries
        TRIG_MASK = 8'h00; POST_COUNT = 6'd5;
        pulse_arm(1'b0);
        bus(1'b1, 1'b0, 8'h40, 8'h01, 2'b00);
        check("s4_post", 32'(STATE), 32'd2);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("s4_idle", 32'(STATE), 32'd0);
        check("s4_count_rst", 32'(COUNT), 32'd0);
        TRIG_ADDR = 8'hFF; TRIG_MASK = 8'hFF;
        pulse_arm(1'b0);
        check("s4_armed", 32'(STATE), 32'd1);
        bus(1'b0, 1'b1, 8'h50, 8'h05, 2'b00);
        bus(1'b1, 1'b0, 8'h51, 8'h06, 2'b00);
        check("s4_count", 32'(COUNT), 32'd2);
        run_reads(4);

        // 5: simultaneous WE/RE is one entry; idle cycles add nothing
        pulse_arm(1'b0);
        for (int i = 0; i < 3; i++) step();
        bus(1'b1, 1'b1, 8'h03, 8'h77, 2'b10);
        for (int i = 0; i < 3; i++) step();
        check("s5_count", 32'(COUNT), 32'd1);
        check("s5_still_armed", 32'(STATE), 32'd1);
        run_reads(5);

        // 6: ARM together with STOP arms; timestamp counts idle cycles
        STOP = 1'b1;
        bus(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
        STOP = 1'b0;
        check("s6_stopped", 32'(STATE), 32'd3);
        pulse_arm(1'b1);
        check("s6_arm_wins", 32'(STATE), 32'd1);
        for (int i = 0; i < 7; i++) step();
        bus(1'b0, 1'b1, 8'h44, 8'h99, 2'b01);
        check("s6_count", 32'(COUNT), 32'd1);
        run_reads(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
